// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave front end.
// The state encoding is one-hot so that any single-bit upset decodes to an illegal code.
package spi_pkg;

    localparam int FRAME_BITS = 10;
    localparam int CNT_W      = 4;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [6:0] {
        ST_IDLE      = 7'b000_0001,
        ST_CHK_CMD   = 7'b000_0010,
        ST_WRITE     = 7'b000_0100,
        ST_READ_ADD  = 7'b000_1000,
        ST_READ_DATA = 7'b001_0000,
        ST_WAIT_TX   = 7'b010_0000,
        ST_SEND      = 7'b100_0000
    } spi_state_e;

endpackage

// File: rtl/spi_piso_shift.sv
// MISO serialiser: loads a readback byte, drives it MSB-first, then holds 0.
// Any cycle that is neither a load nor a shift clears the register so MISO idles low.
module spi_piso_shift
    import spi_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_shift,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_bit
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

    logic [DATA_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_bit;

    // Load / shift / clear of the outgoing byte and its bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_bit   <= 1'b0;
        end else if (i_load) begin
            r_shift <= {i_data[DATA_W-2:0], 1'b0};
            r_bit   <= i_data[DATA_W-1];
            r_cnt   <= CNT_W'(1);
        end else if (i_shift) begin
            if (r_cnt < LAST_CNT) begin
                r_bit   <= r_shift[DATA_W-1];
                r_shift <= {r_shift[DATA_W-2:0], 1'b0};
                r_cnt   <= r_cnt + CNT_W'(1);
            end else begin
                r_bit <= 1'b0;
            end
        end else begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_bit   <= 1'b0;
        end
    end

    assign o_bit = r_bit;

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises 10-bit command frames and serialises RAM readback on MISO.
// MOSI is oversampled on clk, one bit per rising edge while SS_n is low.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [DATA_W+1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid
);

    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(DATA_W + 2);

    spi_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W+1:0] r_rx_shift;
    logic [DATA_W+1:0] r_rx_data;
    logic              r_rx_valid;
    logic              r_rd_addr_seen;
    logic              w_tx_load;
    logic              w_tx_shift;

    assign w_tx_load  = (r_state == ST_WAIT_TX) && !SS_n && tx_valid;
    assign w_tx_shift = (r_state == ST_SEND) && !SS_n;

    // Frame FSM with inline RX deserialiser and read-address tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_rx_shift     <= '0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rd_addr_seen <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt   <= '0;
                    r_state <= SS_n ? ST_IDLE : ST_CHK_CMD;
                end
                ST_CHK_CMD: begin
                    if (SS_n) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_rx_shift <= {r_rx_shift[DATA_W:0], MOSI};
                        r_cnt      <= CNT_W'(1);
                        if (!MOSI) begin
                            r_state <= ST_WRITE;
                        end else if (r_rd_addr_seen) begin
                            r_state <= ST_READ_DATA;
                        end else begin
                            r_state <= ST_READ_ADD;
                        end
                    end
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    // Frame completion wins over a simultaneous SS_n rise
                    if (r_cnt == FRAME_CNT) begin
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                        r_cnt      <= '0;
                        if (r_state == ST_READ_ADD) begin
                            r_rd_addr_seen <= 1'b1;
                        end else if (r_state == ST_READ_DATA) begin
                            r_rd_addr_seen <= 1'b0;
                        end else begin
                            r_rd_addr_seen <= r_rd_addr_seen;
                        end
                        r_state <= ((r_state == ST_READ_DATA) && !SS_n) ? ST_WAIT_TX : ST_IDLE;
                    end else if (SS_n) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_rx_shift <= {r_rx_shift[DATA_W:0], MOSI};
                        r_cnt      <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_TX: begin
                    if (SS_n) begin
                        r_state <= ST_IDLE;
                    end else if (tx_valid) begin
                        r_state <= ST_SEND;
                    end else begin
                        r_state <= ST_WAIT_TX;
                    end
                end
                ST_SEND: begin
                    r_state <= SS_n ? ST_IDLE : ST_SEND;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    spi_piso_shift #(
        .DATA_W (DATA_W)
    ) u_piso (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_tx_load),
        .i_shift (w_tx_shift),
        .i_data  (tx_data),
        .o_bit   (MISO)
    );

    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if with a frame-level scoreboard and a small RAM model.
module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    logic [9:0] exp_rx   [int];
    logic       exp_miso [int];
    logic [9:0] m_data = 10'h000;
    bit         m_rd_seen = 1'b0;
    bit         m_wait = 1'b0;
    logic [7:0] ram [256];
    logic [7:0] m_wr_addr = 8'h00;
    logic [7:0] m_rd_addr = 8'h00;
    logic [7:0] cap;

    spi_slave_if #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the scoreboard
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_rx.exists(cyc)) begin
                m_data = exp_rx[cyc];
                chk("rx_valid_pulse", {31'd0, rx_valid}, 32'd1);
            end else begin
                chk("rx_valid_idle", {31'd0, rx_valid}, 32'd0);
            end
            chk("rx_data", {22'd0, rx_data}, {22'd0, m_data});
            chk("miso", {31'd0, MISO}, exp_miso.exists(cyc) ? {31'd0, exp_miso[cyc]} : 32'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One full frame; returns at the negedge before the rx_valid edge
    task automatic send_frame(input logic [9:0] w);
        int  c;
        bit  rd;
        @(negedge clk);
        SS_n = 1'b0;
        c = cyc;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            MOSI = w[i];
        end
        exp_rx[c + 12] = w;
        rd = w[9] && m_rd_seen;
        if (w[9]) begin
            if (m_rd_seen) begin
                m_rd_seen = 1'b0;
                m_wait    = 1'b1;
            end else begin
                m_rd_seen = 1'b1;
                m_rd_addr = w[7:0];
            end
        end else if (w[8]) begin
            ram[m_wr_addr] = w[7:0];
        end else begin
            m_wr_addr = w[7:0];
        end
        @(negedge clk);
        if (!rd) SS_n = 1'b1;
    endtask

    task automatic abort_frame(input logic [9:0] w, input int nbits);
        @(negedge clk);
        SS_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            MOSI = w[9 - i];
        end
        @(negedge clk);
        SS_n = 1'b1;
    endtask

    // Present readback; expect serialisation only if a read-data frame is pending
    task automatic start_tx(output int t);
        logic [7:0] d;
        @(negedge clk);
        t = cyc;
        d = ram[m_rd_addr];
        tx_data  = d;
        tx_valid = 1'b1;
        if (m_wait) begin
            for (int k = 0; k < 8; k++) exp_miso[t + 1 + k] = d[7 - k];
            m_wait = 1'b0;
        end
    endtask

    task automatic apply_tx(output logic [7:0] c8);
        int t;
        start_tx(t);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            c8[7 - k] = MISO;
            if (k == 7) tx_valid = 1'b0;
        end
    endtask

    initial begin
        int t;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        #3;
        chk("reset_miso", {31'd0, MISO}, 32'd0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_rx_data", {22'd0, rx_data}, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        idle(2);

        // write address then write data
        send_frame(10'h03C);
        idle(3);
        chk("t2_rx_data", {22'd0, rx_data}, 32'h03C);
        send_frame(10'h1A5);
        idle(3);
        chk("t3_rx_data", {22'd0, rx_data}, 32'h1A5);
        chk("t3_ram", {24'd0, ram[8'h3C]}, 32'hA5);

        // read address, read data, readback
        send_frame(10'h23C);
        idle(3);
        chk("t4_rx_addr", {22'd0, rx_data}, 32'h23C);
        send_frame(10'h300);
        apply_tx(cap);
        chk("t4_miso_byte", {24'd0, cap}, 32'hA5);
        idle(4);
        SS_n = 1'b1;
        idle(3);
        chk("t4_rx_data", {22'd0, rx_data}, 32'h300);

        // abort then a clean frame
        abort_frame(10'h0FF, 6);
        idle(3);
        chk("t5_rx_held", {22'd0, rx_data}, 32'h300);
        send_frame(10'h05A);
        idle(3);
        chk("t5_rx_data", {22'd0, rx_data}, 32'h05A);

        // back-to-back writes with one idle cycle between
        send_frame(10'h011);
        send_frame(10'h1C3);
        idle(3);
        chk("t6_rx_data", {22'd0, rx_data}, 32'h1C3);
        chk("t6_ram", {24'd0, ram[8'h11]}, 32'hC3);

        // aborted frame keeps rd_addr_seen, then reset mid-SEND
        send_frame(10'h211);
        idle(2);
        abort_frame(10'h3FF, 4);
        idle(2);
        send_frame(10'h300);
        start_tx(t);
        @(negedge clk);
        chk("t1_miso_pre", {31'd0, MISO}, 32'd1);
        #2;
        chk_en = 1'b0;
        rst_n = 1'b0;
        SS_n = 1'b1;
        tx_valid = 1'b0;
        #1;
        chk("t1_miso", {31'd0, MISO}, 32'd0);
        chk("t1_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("t1_rx_data", {22'd0, rx_data}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        exp_rx.delete();
        exp_miso.delete();
        m_data = 10'h000;
        m_rd_seen = 1'b0;
        m_wait = 1'b0;
        chk_en = 1'b1;
        idle(2);
        send_frame(10'h0AA);
        idle(3);
        chk("post_reset_rx", {22'd0, rx_data}, 32'h0AA);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
